if_id_stage: RTL and testbench

//  IF/ID pipeline register between instruction fetch and decode. Latches the fetched word and pc_4,

---
 rtl/if_id_stage_pkg.sv | 41 ++++
 rtl/if_id_stage_load_use_detect.sv | 31 +++
 rtl/if_id_stage.sv | 203 ++++++++++++++++++++
 tb/tb_if_id_stage.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_id_stage_pkg.sv
// ----------------------------------------------------------------------------
// if_id_stage_pkg
//   Shared definitions for the IF/ID pipeline stage:
//   - MIPS opcode encodings that the hazard logic decodes.
//   - The default bubble encoding (sll $0,$0,0).
//   - FSM state encodings for the IF/ID control FSM.
//   - Operand-usage decode helpers used by load_use_detect.
// ----------------------------------------------------------------------------
package if_id_stage_pkg;

  // Opcode field encodings (inst[31:26]).
  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] J      = 6'h02;
  localparam logic [5:0] JAL    = 6'h03;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] BNE    = 6'h05;
  localparam logic [5:0] LUI    = 6'h0F;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] LBU    = 6'h24;
  localparam logic [5:0] SW     = 6'h2B;

  // sll $0,$0,0 -- architectural no-op used for bubbles.
  localparam logic [31:0] NOP_ENC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IFID_RUN       = 2'd0,
    IFID_HOLD      = 2'd1,
    IFID_IMEM_WAIT = 2'd2
  } ifid_state_e;

  // Every instruction reads rs except the jumps and LUI.
  function automatic logic uses_rs(input logic [5:0] op);
    return !((op == J) || (op == JAL) || (op == LUI));
  endfunction

  // Only R-type, the two compare-branches and SW read rt as a source.
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == R_TYPE) || (op == BEQ) || (op == BNE) || (op == SW);
  endfunction

endpackage

// File: rtl/if_id_stage_load_use_detect.sv
// ----------------------------------------------------------------------------
// load_use_detect
//   Combinational load-use hazard detector. Flags a hazard when the load in
//   EX writes a non-zero register that the instruction in ID reads.
//   Ports:
//     opcode, rs, rt  in   fields of the instruction currently in ID
//     ex_mem_read     in   instruction in EX is a load (LW/LBU)
//     ex_wb_dest      in   destination register of the instruction in EX
//     hazard          out  ID must wait for the load result
// ----------------------------------------------------------------------------
module load_use_detect
  import if_id_stage_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_wb_dest,
  output logic       hazard
);

  logic rs_match;
  logic rt_match;

  assign rs_match = uses_rs(opcode) && (ex_wb_dest == rs);
  assign rt_match = uses_rt(opcode) && (ex_wb_dest == rt);

  // $0 is hardwired, so a load targeting it never produces a dependency.
  assign hazard = ex_mem_read && (ex_wb_dest != 5'd0) && (rs_match || rt_match);

endmodule

// File: rtl/if_id_stage.sv
// ----------------------------------------------------------------------------
// if_id_stage
//   IF/ID pipeline register. Latches the fetched word and PC+4, exposes the
//   decode fields, and owns load-use hazard detection: it produces the stall
//   that control turns into a bubble and the PC write enable. The ISA has a
//   branch delay slot, so nothing is ever flushed here.
//
//   Parameters:
//     LOAD_USE_CYCLES  stall cycles per load-use hazard, legal 1..3
//     NOP_INST         word loaded into ID when fetch has nothing valid
//
//   Ports:
//     clk, rst                       clock (rising), async active-high reset
//     imem_valid, imem_inst, if_pc_4 fetch side
//     ex_mem_read, ex_wb_dest        load in EX, for hazard detection
//     frz                            global freeze, holds every register
//     id_inst, id_pc_4, id_valid     latched ID contents (id_valid=0: bubble)
//     opcode..func, imm16, jaddr     slices of id_inst
//     stall, pc_we                   to control / PC register
//     perf_stall_cnt, perf_bubble_cnt  saturating counters
//
//   Build option: define IFID_PERF_EN to implement the performance counters;
//   without it both counter ports read zero and no counter flops exist.
// ----------------------------------------------------------------------------
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int unsigned  LOAD_USE_CYCLES = 1,
  parameter logic [31:0]  NOP_INST        = NOP_ENC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_valid,
  input  logic [31:0] imem_inst,
  input  logic [31:0] if_pc_4,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_wb_dest,
  input  logic        frz,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc_4,
  output logic        id_valid,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  func,
  output logic [15:0] imm16,
  output logic [25:0] jaddr,
  output logic        stall,
  output logic        pc_we,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_bubble_cnt
);

  ifid_state_e state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        hazard;
  logic        load_fetch;
  logic        load_nop;

  // --------------------------------------------------------------------------
  // Field decode: pure slices, zero latency.
  // --------------------------------------------------------------------------
  assign opcode = id_inst[31:26];
  assign rs     = id_inst[25:21];
  assign rt     = id_inst[20:16];
  assign rd     = id_inst[15:11];
  assign shamt  = id_inst[10:6];
  assign func   = id_inst[5:0];
  assign imm16  = id_inst[15:0];
  assign jaddr  = id_inst[25:0];

  load_use_detect u_load_use_detect (
    .opcode      (opcode),
    .rs          (rs),
    .rt          (rt),
    .ex_mem_read (ex_mem_read),
    .ex_wb_dest  (ex_wb_dest),
    .hazard      (hazard)
  );

  // --------------------------------------------------------------------------
  // Next-state / output logic. Priority: frz > hazard/HOLD > imem_valid.
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that left
    // one unassigned would infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_fetch = 1'b0;
    load_nop   = 1'b0;
    stall      = 1'b0;
    pc_we      = 1'b0;

    if (frz) begin
      stall = 1'b1;
    end else begin
      unique case (state_q)
        IFID_RUN: begin
          if (hazard) begin
            stall = 1'b1;
            // The first stall cycle is this one; HOLD covers the remainder.
            if (LOAD_USE_CYCLES > 1) begin
              cnt_d   = 2'(LOAD_USE_CYCLES - 1);
              state_d = IFID_HOLD;
            end
          end else if (imem_valid) begin
            load_fetch = 1'b1;
            pc_we      = 1'b1;
          end else begin
            load_nop = 1'b1;
            state_d  = IFID_IMEM_WAIT;
          end
        end

        IFID_HOLD: begin
          // The hazard input is ignored here: the EX instruction is already
          // a bubble, and the remaining wait is fixed by cnt.
          stall = 1'b1;
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) begin
            state_d = IFID_RUN;
          end
        end

        IFID_IMEM_WAIT: begin
          if (imem_valid) begin
            load_fetch = 1'b1;
            pc_we      = 1'b1;
            state_d    = IFID_RUN;
          end
        end

        default: begin
          state_d = IFID_RUN;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State and ID registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IFID_RUN;
      cnt_q    <= 2'd0;
      id_inst  <= NOP_INST;
      id_pc_4  <= 32'd0;
      id_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_fetch) begin
        id_inst  <= imem_inst;
        id_pc_4  <= if_pc_4;
        id_valid <= 1'b1;
      end else if (load_nop) begin
        // id_pc_4 is left as-is: it is meaningless while id_valid is low.
        id_inst  <= NOP_INST;
        id_valid <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Performance counters.
  // --------------------------------------------------------------------------
`ifdef IFID_PERF_EN
  logic        bubble;
  logic [31:0] stall_cnt_q;
  logic [31:0] bubble_cnt_q;

  // A bubble is a cycle in which ID is filled with NOP because fetch had
  // nothing; the cycle that finally accepts the fetched word is not one.
  assign bubble = !frz && !imem_valid &&
                  ((state_q == IFID_IMEM_WAIT) || ((state_q == IFID_RUN) && !hazard));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      if (stall && !frz && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (bubble && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`else
  assign perf_stall_cnt  = 32'h0;
  assign perf_bubble_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// ----------------------------------------------------------------------------
// tb_if_id_stage
//   Two instances share all inputs: index 0 has LOAD_USE_CYCLES=1, index 1
//   has LOAD_USE_CYCLES=2. A directed table, hand-written reset/freeze
//   sequences and a randomized phase are checked; a behavioural model
//   (ID contents plus a count of outstanding stall cycles) runs alongside.
// ----------------------------------------------------------------------------
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_valid;
  logic [31:0] imem_inst;
  logic [31:0] if_pc_4;
  logic        ex_mem_read;
  logic [4:0]  ex_wb_dest;
  logic        frz;

  logic [31:0] id_inst_o [2];
  logic [31:0] id_pc_4_o [2];
  logic        id_valid_o[2];
  logic [5:0]  opcode_o  [2];
  logic [4:0]  rs_o      [2];
  logic [4:0]  rt_o      [2];
  logic [4:0]  rd_o      [2];
  logic [4:0]  shamt_o   [2];
  logic [5:0]  func_o    [2];
  logic [15:0] imm16_o   [2];
  logic [25:0] jaddr_o   [2];
  logic        stall_o   [2];
  logic        pc_we_o   [2];
  logic [31:0] pstall_o  [2];
  logic [31:0] pbubble_o [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  if_id_stage #(.LOAD_USE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .imem_valid(imem_valid), .imem_inst(imem_inst),
    .if_pc_4(if_pc_4), .ex_mem_read(ex_mem_read), .ex_wb_dest(ex_wb_dest), .frz(frz),
    .id_inst(id_inst_o[0]), .id_pc_4(id_pc_4_o[0]), .id_valid(id_valid_o[0]),
    .opcode(opcode_o[0]), .rs(rs_o[0]), .rt(rt_o[0]), .rd(rd_o[0]), .shamt(shamt_o[0]),
    .func(func_o[0]), .imm16(imm16_o[0]), .jaddr(jaddr_o[0]), .stall(stall_o[0]),
    .pc_we(pc_we_o[0]), .perf_stall_cnt(pstall_o[0]), .perf_bubble_cnt(pbubble_o[0])
  );

  if_id_stage #(.LOAD_USE_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .imem_valid(imem_valid), .imem_inst(imem_inst),
    .if_pc_4(if_pc_4), .ex_mem_read(ex_mem_read), .ex_wb_dest(ex_wb_dest), .frz(frz),
    .id_inst(id_inst_o[1]), .id_pc_4(id_pc_4_o[1]), .id_valid(id_valid_o[1]),
    .opcode(opcode_o[1]), .rs(rs_o[1]), .rt(rt_o[1]), .rd(rd_o[1]), .shamt(shamt_o[1]),
    .func(func_o[1]), .imm16(imm16_o[1]), .jaddr(jaddr_o[1]), .stall(stall_o[1]),
    .pc_we(pc_we_o[1]), .perf_stall_cnt(pstall_o[1]), .perf_bubble_cnt(pbubble_o[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: what ID holds, and how many stall cycles remain after
  // the current one for an already detected load-use hazard.
  // --------------------------------------------------------------------------
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    bit          valid;
    int          hold_left;
    int          stalls;
    int          bubbles;
  } model_t;

  model_t md[2];
  int     lu_cycles[2] = '{1, 2};

  function automatic bit ref_hazard(input logic [31:0] inst, input bit mr, input logic [4:0] dest);
    logic [5:0] op  = inst[31:26];
    bit         urs = !(op inside {6'h02, 6'h03, 6'h0F});
    bit         urt = op inside {6'h00, 6'h04, 6'h05, 6'h2B};
    return mr && (dest != 5'd0) &&
           ((urs && dest == inst[25:21]) || (urt && dest == inst[20:16]));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      md[k].inst = 32'h0; md[k].pc = 32'h0; md[k].valid = 1'b0;
      md[k].hold_left = 0; md[k].stalls = 0; md[k].bubbles = 0;
    end
  endtask

  // Compare instance k against the model for the inputs now applied, then
  // advance the model to what the next rising edge should produce.
  task automatic model_step(input int k);
    bit     e_stall = 1'b0;
    bit     e_we    = 1'b0;
    model_t n       = md[k];
    if (frz) begin
      e_stall = 1'b1;
    end else if (md[k].hold_left > 0) begin
      e_stall = 1'b1;
      n.hold_left--;
    end else if (ref_hazard(md[k].inst, ex_mem_read, ex_wb_dest)) begin
      e_stall = 1'b1;
      n.hold_left = lu_cycles[k] - 1;
    end else if (imem_valid) begin
      e_we = 1'b1;
      n.inst = imem_inst; n.pc = if_pc_4; n.valid = 1'b1;
    end else begin
      n.inst = 32'h0; n.valid = 1'b0;
      n.bubbles++;
    end
    if (e_stall && !frz) n.stalls++;

    check($sformatf("model_stall[%0d]", k), 32'(stall_o[k]), 32'(e_stall));
    check($sformatf("model_pc_we[%0d]", k), 32'(pc_we_o[k]), 32'(e_we));
    check($sformatf("model_id_inst[%0d]", k), id_inst_o[k], md[k].inst);
    check($sformatf("model_id_valid[%0d]", k), 32'(id_valid_o[k]), 32'(md[k].valid));
    if (md[k].valid) check($sformatf("model_id_pc_4[%0d]", k), id_pc_4_o[k], md[k].pc);
    check($sformatf("fields[%0d]", k),
          {opcode_o[k], rs_o[k], rt_o[k], rd_o[k], shamt_o[k], func_o[k]}, md[k].inst);
    check($sformatf("imm16[%0d]", k), 32'(imm16_o[k]), 32'(md[k].inst[15:0]));
    check($sformatf("jaddr[%0d]", k), 32'(jaddr_o[k]), 32'(md[k].inst[25:0]));
    md[k] = n;
  endtask

  // Called at a falling edge: apply inputs, settle, model-check both DUTs.
  // The caller adds any directed checks and then advances with next_cycle.
  task automatic drive_cycle(input bit iv, input logic [31:0] inst, input logic [31:0] pc,
                             input bit exr, input logic [4:0] dest, input bit fz);
    imem_valid = iv; imem_inst = inst; if_pc_4 = pc;
    ex_mem_read = exr; ex_wb_dest = dest; frz = fz;
    #1;
    model_step(0);
    model_step(1);
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic check_perf(input string tag, input int s0, input int b0, input int s1, input int b1);
`ifdef IFID_PERF_EN
    check({tag, "_stall0"},  pstall_o[0],  32'(s0));
    check({tag, "_bubble0"}, pbubble_o[0], 32'(b0));
    check({tag, "_stall1"},  pstall_o[1],  32'(s1));
    check({tag, "_bubble1"}, pbubble_o[1], 32'(b1));
`else
    check({tag, "_stall0"},  pstall_o[0],  32'(s0 * 0));
    check({tag, "_bubble0"}, pbubble_o[0], 32'(b0 * 0));
    check({tag, "_stall1"},  pstall_o[1],  32'(s1 * 0));
    check({tag, "_bubble1"}, pbubble_o[1], 32'(b1 * 0));
`endif
  endtask

  // --------------------------------------------------------------------------
  // Directed table. Expected values are those visible before the rising edge
  // that follows the applied inputs.
  // --------------------------------------------------------------------------
  typedef struct {
    bit          iv;
    logic [31:0] inst;
    logic [31:0] pc;
    bit          exr;
    logic [4:0]  dest;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    bit          chk_pc;
    bit          e_valid;
    bit          e_stall;
    bit          e_we;
    logic [31:0] e_inst2;
    bit          e_stall2;
    bit          e_we2;
  } vec_t;

  localparam logic [31:0] ADD  = 32'h0022_1820;  // add $3,$1,$2
  localparam logic [31:0] LUI2 = 32'h3C02_1234;  // lui $2,0x1234
  localparam logic [31:0] LW   = 32'h8C43_0004;  // lw  $3,4($2)
  localparam logic [31:0] ADD8 = 32'h012A_4020;  // add $8,$9,$10
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  vec_t tbl[12];
  logic [5:0] ops[10] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h0F, 6'h23, 6'h24, 6'h2B, 6'h08};

  initial begin
    //           iv inst  pc        exr dst e_inst e_pc      cpc v  st we e_inst2 st2 we2
    tbl[0]  = '{1, ADD,  32'h104, 0, 0, 32'h0, 32'h0,   1, 0, 0, 1, 32'h0, 0, 1};
    tbl[1]  = '{1, LUI2, 32'h108, 1, 2, ADD,   32'h104, 1, 1, 1, 0, ADD,   1, 0};
    tbl[2]  = '{1, LUI2, 32'h108, 0, 0, ADD,   32'h104, 1, 1, 0, 1, ADD,   1, 0};
    tbl[3]  = '{1, LUI2, 32'h108, 0, 0, LUI2,  32'h108, 1, 1, 0, 1, ADD,   0, 1};
    tbl[4]  = '{1, LUI2, 32'h108, 1, 2, LUI2,  32'h108, 1, 1, 0, 1, LUI2,  0, 1};
    tbl[5]  = '{1, LUI2, 32'h108, 1, 0, LUI2,  32'h108, 1, 1, 0, 1, LUI2,  0, 1};
    tbl[6]  = '{0, JUNK, 32'h999, 0, 0, LUI2,  32'h108, 1, 1, 0, 0, LUI2,  0, 0};
    tbl[7]  = '{0, JUNK, 32'h999, 0, 0, 32'h0, 32'h0,   0, 0, 0, 0, 32'h0, 0, 0};
    tbl[8]  = '{0, JUNK, 32'h999, 0, 0, 32'h0, 32'h0,   0, 0, 0, 0, 32'h0, 0, 0};
    tbl[9]  = '{1, LW,   32'h10C, 0, 0, 32'h0, 32'h0,   0, 0, 0, 1, 32'h0, 0, 1};
    tbl[10] = '{1, ADD8, 32'h110, 0, 0, LW,    32'h10C, 1, 1, 0, 1, LW,    0, 1};
    tbl[11] = '{1, ADD8, 32'h114, 0, 0, ADD8,  32'h110, 1, 1, 0, 1, ADD8,  0, 1};

    // Reset, checked with fetch valid so pc_we reflects the RUN state.
    rst = 1'b1; imem_valid = 1'b1; imem_inst = ADD; if_pc_4 = 32'h100;
    ex_mem_read = 1'b0; ex_wb_dest = 5'd0; frz = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_id_inst", id_inst_o[k], 32'h0);
      check("rst_id_pc_4", id_pc_4_o[k], 32'h0);
      check("rst_id_valid", 32'(id_valid_o[k]), 32'h0);
      check("rst_stall", 32'(stall_o[k]), 32'h0);
      check("rst_pc_we", 32'(pc_we_o[k]), 32'h1);
    end
    check_perf("rst_perf", 0, 0, 0, 0);
    rst = 1'b0;

    // Table: load-use stall of 1 vs 2 cycles, LUI no-hazard, fetch gap.
    for (int i = 0; i < 12; i++) begin
      drive_cycle(tbl[i].iv, tbl[i].inst, tbl[i].pc, tbl[i].exr, tbl[i].dest, 1'b0);
      check($sformatf("tbl%0d_id_inst", i), id_inst_o[0], tbl[i].e_inst);
      if (tbl[i].chk_pc) check($sformatf("tbl%0d_id_pc_4", i), id_pc_4_o[0], tbl[i].e_pc);
      check($sformatf("tbl%0d_id_valid", i), 32'(id_valid_o[0]), 32'(tbl[i].e_valid));
      check($sformatf("tbl%0d_stall", i), 32'(stall_o[0]), 32'(tbl[i].e_stall));
      check($sformatf("tbl%0d_pc_we", i), 32'(pc_we_o[0]), 32'(tbl[i].e_we));
      check($sformatf("tbl%0d_id_inst2", i), id_inst_o[1], tbl[i].e_inst2);
      check($sformatf("tbl%0d_stall2", i), 32'(stall_o[1]), 32'(tbl[i].e_stall2));
      check($sformatf("tbl%0d_pc_we2", i), 32'(pc_we_o[1]), 32'(tbl[i].e_we2));
      next_cycle();
    end
    #1;
    check_perf("tbl_perf", 1, 3, 2, 3);

    // Reset asserted while the LOAD_USE_CYCLES=2 instance sits in HOLD.
    drive_cycle(1'b1, ADD, 32'h200, 1'b0, 5'd0, 1'b0);
    next_cycle();
    drive_cycle(1'b1, JUNK, 32'h204, 1'b1, 5'd2, 1'b0);
    check("mid_hold_stall2", 32'(stall_o[1]), 32'h1);
    next_cycle();
    rst = 1'b1; imem_valid = 1'b1; ex_mem_read = 1'b1; ex_wb_dest = 5'd2; frz = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      check("rst_hold_id_inst", id_inst_o[k], 32'h0);
      check("rst_hold_id_valid", 32'(id_valid_o[k]), 32'h0);
      check("rst_hold_stall", 32'(stall_o[k]), 32'h0);
      check("rst_hold_pc_we", 32'(pc_we_o[k]), 32'h1);
    end
    next_cycle();
    rst = 1'b0;

    // Freeze during HOLD (cnt=1): frozen, then exactly one more stall.
    drive_cycle(1'b1, ADD, 32'h300, 1'b0, 5'd0, 1'b0);
    next_cycle();
    drive_cycle(1'b1, JUNK, 32'h304, 1'b1, 5'd1, 1'b0);
    check("frz_entry_stall2", 32'(stall_o[1]), 32'h1);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, JUNK, 32'h304, 1'b0, 5'd0, 1'b1);
      check("frz_stall1", 32'(stall_o[0]), 32'h1);
      check("frz_stall2", 32'(stall_o[1]), 32'h1);
      check("frz_pc_we2", 32'(pc_we_o[1]), 32'h0);
      check("frz_id_inst2", id_inst_o[1], ADD);
      next_cycle();
    end
    drive_cycle(1'b1, JUNK, 32'h304, 1'b0, 5'd0, 1'b0);
    check("post_frz_stall2", 32'(stall_o[1]), 32'h1);
    check("post_frz_stall1", 32'(stall_o[0]), 32'h0);
    next_cycle();
    drive_cycle(1'b1, JUNK, 32'h304, 1'b0, 5'd0, 1'b0);
    check("post_frz_done2", 32'(stall_o[1]), 32'h0);
    check("post_frz_pc_we2", 32'(pc_we_o[1]), 32'h1);
    next_cycle();

    // Randomized phase against the model; small register range to provoke hazards.
    for (int c = 0; c < 800; c++) begin
      logic [31:0] w = $urandom;
      w[31:26] = ops[$urandom_range(0, 9)];
      w[25:21] = 5'($urandom_range(0, 3));
      w[20:16] = 5'($urandom_range(0, 3));
      drive_cycle($urandom_range(0, 9) < 8, w, $urandom, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
      next_cycle();
    end
    #1;
    check_perf("final_perf", md[0].stalls, md[0].bubbles, md[1].stalls, md[1].bubbles);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
